i2c_tx_frame_sr: RTL and testbench
==================================

# i2c_tx_frame_sr

Parametrised I2C transmit shifter for the Triple DES slave datapath. It serialises a DATA_WIDTH-bit word as BYTE_BITS-bit bytes on SCL falling edges and releases SDA for each acknowledge slot. It samples the master's ACK/NACK on the SCL rising edge and aborts the frame on NACK. It sits between the output block buffer and the SDA output mux, driven by the edge detector and the slave controller.

## Interface
- DATA_WIDTH, default 64: total bits per frame; must be a multiple of BYTE_BITS.
- BYTE_BITS, default 8: bits per byte before each ACK slot.
- SHIFT_MSB, default 1: 1 = MSB-first within the frame, 0 = LSB-first.
- IDLE_VAL, default 1: tx_out value when idle or in an ACK slot (SDA released).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_data  in  1  capture tx_data and start a frame; honoured only in IDLE.
- tx_data  in  DATA_WIDTH  frame payload.
- tx_enable  in  1  qualifies both edge strobes; low freezes the block.
- falling_edge_found  in  1  one-cycle SCL falling-edge strobe.
- rising_edge_found  in  1  one-cycle SCL rising-edge strobe.
- sda_in  in  1  synchronised SDA, read in ACK slots (0 = ACK).
- tx_out  out  1  serial data toward the SDA driver.
- busy  out  1  high in any state other than IDLE.
- byte_done  out  1  one-cycle pulse when a byte is ACKed.
- frame_done  out  1  one-cycle pulse when the last byte is ACKed.
- ack_error  out  1  one-cycle pulse on NACK; the frame is aborted.

## Operation
- NUM_BYTES = DATA_WIDTH/BYTE_BITS.
- bit_cnt width: clog2(BYTE_BITS). byte_cnt width: clog2(NUM_BYTES), minimum 1 bit.
- fe = falling_edge_found & tx_enable. re = rising_edge_found & tx_enable.
- States:
  - IDLE: tx_out = IDLE_VAL. On load_data, capture tx_data, clear both counters, go to SHIFT.
  - SHIFT: tx_out = current head bit. On fe, shift one bit and increment bit_cnt. On the fe where bit_cnt = BYTE_BITS-1, clear bit_cnt and go to ACK_SAMPLE; no shift occurs on that edge.
  - ACK_SAMPLE: tx_out = IDLE_VAL. On re, latch ack = ~sda_in and go to ACK_END.
  - ACK_END: tx_out = IDLE_VAL. On fe:
    - NACK: pulse ack_error, go to IDLE.
    - ACK and byte_cnt = NUM_BYTES-1: pulse byte_done and frame_done, go to IDLE.
    - Otherwise: pulse byte_done, increment byte_cnt, shift once to present the next byte's first bit, go to SHIFT.
- Shift order:
  - SHIFT_MSB=1: head = sr[DATA_WIDTH-1], shift left, fill 1.
  - SHIFT_MSB=0: head = sr[0], shift right, fill 1.
- Ignored events:
  - load_data while busy is ignored; the payload is not recaptured.
  - re in SHIFT and ACK_END is ignored.
  - fe in ACK_SAMPLE is ignored.
  - If re and fe arrive in the same cycle, only the one relevant to the current state acts.
- rst at any point returns to IDLE within one cycle. No pulse outputs are emitted.

## Timing
- Reset values: tx_out = IDLE_VAL; busy, byte_done, frame_done, ack_error = 0; state IDLE; sr all ones; counters 0.
- All outputs are registered.
- After load_data at cycle N, tx_out shows the first bit at N+1, and busy = 1 at N+1.
- After an fe strobe at cycle N, the new bit appears on tx_out at N+1. This meets I2C data-hold because the change happens in SCL low.
- Pulses (byte_done, frame_done, ack_error) are high for exactly the cycle after the qualifying fe.
- busy falls in the same cycle as frame_done or ack_error.
- tx_enable low holds state, counters, and tx_out indefinitely.

## Structure
- Shared package i2c_tx_pkg holds:
  - state typedef enum logic [1:0] {IDLE, SHIFT, ACK_SAMPLE, ACK_END};
  - the ACK polarity constant.
- Sub-module sync_pts_sr: parametrised parallel-to-serial register with load, shift_enable, SHIFT_MSB, and synchronous active-high reset.
- Counters and FSM live in the top module.

## Test plan
- Load (DATA_WIDTH=16, SHIFT_MSB=1) 16'hA5C3; ACK both bytes -> tx_out bits 1010_0101, release, 1100_0011, release; two byte_done pulses; frame_done on the second.
- SHIFT_MSB=0, 16'h0001 -> first bit on tx_out = 1, followed by 15 zeros (with ACK slot after bit 8).
- Drive sda_in=1 at the first ACK rising edge -> ack_error pulse on the next fe; busy=0; tx_out=1; second byte never driven.
- Hold tx_enable=0 for 20 cycles mid-byte with strobes toggling -> tx_out and bit position unchanged; resumes correctly afterwards.
- Assert load_data with 16'hFFFF mid-frame -> ignored; the original payload completes.
- Assert rst during ACK_END -> next cycle IDLE, tx_out=1, no pulses; a subsequent load works normally.

Source files
------------

// File: rtl/i2c_tx_pkg.sv
// Shared types and constants for the I2C transmit frame shifter.
package i2c_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACK_SAMPLE,
        ACK_END
    } state_t;

    // SDA level the master drives in the ACK slot to acknowledge a byte
    localparam logic ACK_LEVEL = 1'b0;

endpackage

// File: rtl/i2c_tx_frame_sr_sync_pts_sr.sv
// Parallel-to-serial register: load a word, shift one bit per request, fill with ones.
// Exposes the head bit the register will hold after this cycle so the owner can register it.
module sync_pts_sr #(
    parameter int DATA_WIDTH = 64,
    parameter int SHIFT_MSB  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift_en,
    output logic                  head_next
);

    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic [DATA_WIDTH-1:0] shifted;

    generate
        if (SHIFT_MSB != 0) begin : g_msb
            assign shifted   = {sr[DATA_WIDTH-2:0], 1'b1};
            assign head_next = sr_next[DATA_WIDTH-1];
        end else begin : g_lsb
            assign shifted   = {1'b1, sr[DATA_WIDTH-1:1]};
            assign head_next = sr_next[0];
        end
    endgenerate

    always_comb begin
        sr_next = sr;
        if (load)
            sr_next = data;
        else if (shift_en)
            sr_next = shifted;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sr <= '1;
        else
            sr <= sr_next;
    end

endmodule

// File: rtl/i2c_tx_frame_sr.sv
// I2C slave transmit shifter: sends a word as bytes on SCL falling edges,
// releases SDA for each ACK slot and aborts the frame on NACK.
module i2c_tx_frame_sr
    import i2c_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_BITS  = 8,
    parameter int SHIFT_MSB  = 1,
    parameter bit IDLE_VAL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_data,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_enable,
    input  logic                  falling_edge_found,
    input  logic                  rising_edge_found,
    input  logic                  sda_in,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  byte_done,
    output logic                  frame_done,
    output logic                  ack_error
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_BITS;
    localparam int BIT_W     = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_BITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    state_t              state, state_next;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_next;
    logic [BYTE_W-1:0]   byte_cnt, byte_cnt_next;
    logic                ack, ack_next;
    logic                load_en, shift_en, head_next;
    logic                byte_done_next, frame_done_next, ack_error_next;
    logic                tx_next;
    logic                fe, re;

    assign fe = falling_edge_found & tx_enable;
    assign re = rising_edge_found & tx_enable;

    sync_pts_sr #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_MSB  (SHIFT_MSB)
    ) u_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (load_en),
        .data      (tx_data),
        .shift_en  (shift_en),
        .head_next (head_next)
    );

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        byte_cnt_next   = byte_cnt;
        ack_next        = ack;
        load_en         = 1'b0;
        shift_en        = 1'b0;
        byte_done_next  = 1'b0;
        frame_done_next = 1'b0;
        ack_error_next  = 1'b0;
        case (state)
            IDLE: begin
                if (load_data) begin
                    load_en       = 1'b1;
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // The last bit's falling edge opens the ACK slot without shifting;
                // the shift for the next byte happens when the ACK slot closes.
                if (fe) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = ACK_SAMPLE;
                    end else begin
                        shift_en     = 1'b1;
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ACK_SAMPLE: begin
                if (re) begin
                    ack_next   = (sda_in == ACK_LEVEL);
                    state_next = ACK_END;
                end
            end
            ACK_END: begin
                if (fe) begin
                    if (!ack) begin
                        ack_error_next = 1'b1;
                        state_next     = IDLE;
                    end else if (byte_cnt == BYTE_LAST) begin
                        byte_done_next  = 1'b1;
                        frame_done_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        byte_done_next = 1'b1;
                        byte_cnt_next  = byte_cnt + 1'b1;
                        shift_en       = 1'b1;
                        state_next     = SHIFT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        tx_next = (state_next == SHIFT) ? head_next : IDLE_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            ack        <= 1'b0;
            tx_out     <= IDLE_VAL;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
            frame_done <= 1'b0;
            ack_error  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            byte_cnt   <= byte_cnt_next;
            ack        <= ack_next;
            tx_out     <= tx_next;
            busy       <= (state_next != IDLE);
            byte_done  <= byte_done_next;
            frame_done <= frame_done_next;
            ack_error  <= ack_error_next;
        end
    end

endmodule

// File: tb/tb_i2c_tx_frame_sr.sv
// Scoreboard bench: two 16-bit instances (MSB-first and LSB-first) share all stimulus;
// the receiver-side monitor samples tx_out on each qualified rising edge and checks pulses.
module tb_i2c_tx_frame_sr;

    localparam int DW = 16;
    localparam int BB = 8;
    localparam int NB = DW / BB;

    typedef struct packed {
        logic bd;
        logic fd;
        logic ae;
        logic busy;
    } pulse_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_data = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_enable = 1'b1;
    logic          falling_edge_found = 1'b0;
    logic          rising_edge_found = 1'b0;
    logic          sda_in = 1'b1;

    logic tx_m, busy_m, bd_m, fd_m, ae_m;
    logic tx_l, busy_l, bd_l, fd_l, ae_l;

    int total = 0;
    int bad   = 0;

    logic   qm[$];
    logic   ql[$];
    pulse_t pq[$];

    always #5 clk = ~clk;

    i2c_tx_frame_sr #(.DATA_WIDTH(DW), .BYTE_BITS(BB), .SHIFT_MSB(1), .IDLE_VAL(1'b1)) dut_m (
        .clk(clk), .rst(rst), .load_data(load_data), .tx_data(tx_data), .tx_enable(tx_enable),
        .falling_edge_found(falling_edge_found), .rising_edge_found(rising_edge_found),
        .sda_in(sda_in), .tx_out(tx_m), .busy(busy_m), .byte_done(bd_m),
        .frame_done(fd_m), .ack_error(ae_m)
    );

    i2c_tx_frame_sr #(.DATA_WIDTH(DW), .BYTE_BITS(BB), .SHIFT_MSB(0), .IDLE_VAL(1'b1)) dut_l (
        .clk(clk), .rst(rst), .load_data(load_data), .tx_data(tx_data), .tx_enable(tx_enable),
        .falling_edge_found(falling_edge_found), .rising_edge_found(rising_edge_found),
        .sda_in(sda_in), .tx_out(tx_l), .busy(busy_l), .byte_done(bd_l),
        .frame_done(fd_l), .ack_error(ae_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver side: reads SDA on every qualified rising edge, and checks every pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (rising_edge_found && tx_enable) begin
                if (qm.size() == 0 || ql.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sample_unexpected: got sample with empty queue expected none at %0t", $time);
                end else begin
                    chk("bit_msb", tx_m, qm.pop_front());
                    chk("bit_lsb", tx_l, ql.pop_front());
                end
            end
            if (bd_m | fd_m | ae_m | bd_l | fd_l | ae_l) begin
                if (pq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pulse_unexpected: got %b/%b expected no pulse at %0t",
                             {bd_m, fd_m, ae_m}, {bd_l, fd_l, ae_l}, $time);
                end else begin
                    pulse_t p;
                    p = pq.pop_front();
                    chk("pulse_msb", {bd_m, fd_m, ae_m, busy_m}, p);
                    chk("pulse_lsb", {bd_l, fd_l, ae_l, busy_l}, p);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic tick(input bit f, input bit r);
        falling_edge_found = f;
        rising_edge_found  = r;
        tx_enable          = 1'b1;
        cyc();
        falling_edge_found = 1'b0;
        rising_edge_found  = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic check_idle(input string name);
        chk({name, "_busy"}, {busy_m, busy_l}, 2'b00);
        chk({name, "_tx"},   {tx_m, tx_l},     2'b11);
    endtask

    task automatic freeze();
        logic m0, l0;
        m0 = tx_m;
        l0 = tx_l;
        tx_enable = 1'b0;
        repeat (20) begin
            falling_edge_found = 1'($urandom_range(0, 1));
            rising_edge_found  = 1'($urandom_range(0, 1));
            cyc();
        end
        falling_edge_found = 1'b0;
        rising_edge_found  = 1'b0;
        tx_enable = 1'b1;
        chk("freeze_tx", {tx_m, tx_l}, {m0, l0});
    endtask

    // Reference: byte b bit i is frame bit k=b*BB+i; MSB-first sends data[DW-1-k], LSB-first data[k].
    task automatic run_frame(input logic [DW-1:0] data, input int nack_b, input int freeze_k,
                             input int load_k, input int rst_b);
        tx_data   = data;
        load_data = 1'b1;
        cyc();
        load_data = 1'b0;
        chk("load_busy", {busy_m, busy_l}, 2'b11);
        chk("load_first", {tx_m, tx_l}, {data[DW-1], data[0]});
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < BB; i++) begin
                int k;
                k = b * BB + i;
                qm.push_back(data[DW-1-k]);
                ql.push_back(data[k]);
                tick(1'b0, 1'b1);
                if ($urandom_range(0, 7) == 0) begin
                    qm.push_back(data[DW-1-k]);
                    ql.push_back(data[k]);
                    tick(1'b0, 1'b1);
                end
                if (k == freeze_k) freeze();
                if (k == load_k) begin
                    tx_data   = 16'hFFFF;
                    load_data = 1'b1;
                    cyc();
                    load_data = 1'b0;
                    tx_data   = data;
                end
                tick(1'b1, 1'b0);
            end
            sda_in = (b == nack_b);
            qm.push_back(1'b1);
            ql.push_back(1'b1);
            tick(1'($urandom_range(0, 1)), 1'b1);
            sda_in = 1'($urandom_range(0, 1));
            if (b == rst_b) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                check_idle("rst_ackend");
                tick(1'b1, 1'b0);
                return;
            end
            if (b == nack_b)
                pq.push_back('{bd: 1'b0, fd: 1'b0, ae: 1'b1, busy: 1'b0});
            else if (b == NB - 1)
                pq.push_back('{bd: 1'b1, fd: 1'b1, ae: 1'b0, busy: 1'b0});
            else
                pq.push_back('{bd: 1'b1, fd: 1'b0, ae: 1'b0, busy: 1'b1});
            tick(1'b1, 1'b0);
            if (b == nack_b) begin
                check_idle("nack");
                qm.push_back(1'b1);
                ql.push_back(1'b1);
                tick(1'b0, 1'b1);
                tick(1'b1, 1'b0);
                return;
            end
        end
        check_idle("frame_end");
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        chk("reset_out", {tx_m, busy_m, bd_m, fd_m, ae_m}, 5'b10000);
        chk("reset_out_l", {tx_l, busy_l, bd_l, fd_l, ae_l}, 5'b10000);

        run_frame(16'hA5C3, -1, -1, -1, -1);
        run_frame(16'h0001, -1, -1, -1, -1);
        run_frame(16'h5A3C, 0, -1, -1, -1);
        run_frame(16'h3C5A, -1, 3, -1, -1);
        run_frame(16'h1234, -1, -1, 5, -1);
        run_frame(16'hBEEF, -1, -1, -1, 0);
        run_frame(16'hA5C3, -1, -1, -1, -1);

        for (int n = 0; n < 40; n++) begin
            int nb, fk, lk;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            fk = int'($urandom_range(0, 31));
            lk = int'($urandom_range(0, 31));
            run_frame(16'($urandom), nb, fk, lk, -1);
            repeat ($urandom_range(0, 3)) cyc();
        end

        repeat (4) cyc();
        chk("drain_qm", qm.size(), 0);
        chk("drain_ql", ql.size(), 0);
        chk("drain_pq", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
